// File: rtl/mem_line_adapter_if.sv
// rtl/mem_line_adapter_if.sv - req/ack main-memory beat port between mem_line_adapter and memory
interface mem_line_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [WORD_W-1:0] ext_wdata;
    logic [WORD_W-1:0] ext_rdata;
    logic              ext_ack;

    modport master (
        output ext_req,
        output ext_we,
        output ext_addr,
        output ext_wdata,
        input  ext_rdata,
        input  ext_ack
    );

    modport slave (
        input  ext_req,
        input  ext_we,
        input  ext_addr,
        input  ext_wdata,
        output ext_rdata,
        output ext_ack
    );
endinterface

// File: rtl/mem_line_adapter.sv
// rtl/mem_line_adapter.sv - cache line fill/writeback burst adapter onto a req/ack memory port
// Optional per-beat ack timeout with error/ERR state when MEM_TIMEOUT_EN is defined.
module mem_line_adapter #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [ADDR_W-1:0]            line_addr,
    input  logic [WORD_W*LINE_WORDS-1:0] wb_line,
    output logic [WORD_W*LINE_WORDS-1:0] fill_line,
    output logic                         ca_resp,
    output logic                         busy,
    output logic                         error,
    mem_line_adapter_if.master           mem
);

    localparam int BPW    = WORD_W / 8;
    localparam int OFF    = $clog2(LINE_WORDS * BPW);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE, S_ERR} state_t;
    logic [TO_W-1:0] to_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
`endif

    state_t                         state;
    logic [BEAT_W-1:0]              beat;
    logic [BEAT_W-1:0]              next_beat;
    logic                           last_beat;
    logic [ADDR_W-1:0]              base_addr;
    logic [ADDR_W-1:0]              next_addr;
    logic [WORD_W-1:0]              next_wdata;
    logic [WORD_W*LINE_WORDS-1:0]   wb_buf;
    logic                           any_req;

    assign any_req    = mem_read || mem_write;
    assign next_beat  = beat + 1'b1;
    assign last_beat  = (beat == BEAT_W'(LINE_WORDS - 1));
    // Line base is aligned, so the beat offset never carries into the line address bits.
    assign next_addr  = base_addr + ADDR_W'(int'(next_beat) * BPW);
    assign next_wdata = wb_buf[int'(next_beat)*WORD_W +: WORD_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            beat          <= '0;
            base_addr     <= '0;
            wb_buf        <= '0;
            fill_line     <= '0;
            ca_resp       <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            mem.ext_req   <= 1'b0;
            mem.ext_we    <= 1'b0;
            mem.ext_addr  <= '0;
            mem.ext_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            ca_resp <= 1'b0;
            error   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_read && mem_write) begin
                        error <= 1'b1;
                    end else if (any_req) begin
                        base_addr    <= line_addr & ~OFF_MASK;
                        mem.ext_addr <= line_addr & ~OFF_MASK;
                        mem.ext_we   <= mem_write;
                        mem.ext_req  <= 1'b1;
                        busy         <= 1'b1;
                        beat         <= '0;
                        state        <= S_XFER;
                        if (mem_write) begin
                            wb_buf        <= wb_line;
                            mem.ext_wdata <= wb_line[WORD_W-1:0];
                        end
                    end
                end
                S_XFER: begin
                    if (any_req) error <= 1'b1;
                    if (mem.ext_ack) begin
                        if (!mem.ext_we) fill_line[int'(beat)*WORD_W +: WORD_W] <= mem.ext_rdata;
`ifdef MEM_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (last_beat) begin
                            mem.ext_req <= 1'b0;
                            ca_resp     <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            beat          <= next_beat;
                            mem.ext_addr  <= next_addr;
                            mem.ext_wdata <= next_wdata;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        mem.ext_req <= 1'b0;
                        error       <= 1'b1;
                        ca_resp     <= 1'b1;
                        state       <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (any_req) error <= 1'b1;
                    busy  <= 1'b0;
                    beat  <= '0;
                    state <= S_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                S_ERR: begin
                    if (any_req) error <= 1'b1;
                    busy   <= 1'b0;
                    beat   <= '0;
                    to_cnt <= '0;
                    state  <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_adapter.sv
// tb/tb_mem_line_adapter.sv - randomized self-checking bench for mem_line_adapter with a line-level model
module tb_mem_line_adapter;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int LW = 8;
    localparam int LB = WW * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [AW-1:0] line_addr;
    logic [LB-1:0] wb_line;
    logic [LB-1:0] fill_line;
    logic          ca_resp, busy, error;

    mem_line_adapter_if #(.ADDR_W(AW), .WORD_W(WW)) mem_bus ();

    mem_line_adapter #(.ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .line_addr (line_addr),
        .wb_line   (wb_line),
        .fill_line (fill_line),
        .ca_resp   (ca_resp),
        .busy      (busy),
        .error     (error),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int n_resp_seen = 0;
    int n_err_seen = 0;

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: per-beat wait count, data = read_base + word index within the line.
    int            mem_wait = 0;
    bit            wait_rand = 0;
    bit            mem_stall = 0;
    bit            spurious_en = 0;
    logic [31:0]   read_base = 32'h0;
    logic [AW-1:0] log_addr[$];
    logic          log_we[$];
    logic [WW-1:0] log_wdata[$];

    initial begin
        int wcnt = 0;
        int wtarget = 0;
        mem_bus.ext_ack   = 1'b0;
        mem_bus.ext_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_bus.ext_ack = 1'b0;
                wcnt = 0;
            end else if (mem_bus.ext_req) begin
                if (!mem_stall && wcnt >= wtarget) begin
                    mem_bus.ext_ack   = 1'b1;
                    mem_bus.ext_rdata = read_base + ((mem_bus.ext_addr >> 2) & 32'h7);
                    log_addr.push_back(mem_bus.ext_addr);
                    log_we.push_back(mem_bus.ext_we);
                    log_wdata.push_back(mem_bus.ext_wdata);
                    wcnt = 0;
                    wtarget = wait_rand ? int'($urandom_range(0, 3)) : mem_wait;
                end else begin
                    mem_bus.ext_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_bus.ext_ack   = spurious_en && ($urandom_range(0, 3) == 0);
                mem_bus.ext_rdata = $urandom;
                wcnt = 0;
                wtarget = wait_rand ? int'($urandom_range(0, 3)) : mem_wait;
            end
        end
    end

    // Line-level model: phase 0 idle, 1 transferring beat m_beat, 2 completion cycle.
    int            m_phase = 0;
    int            m_beat = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_base = '0;
    logic [LB-1:0] m_wb = '0;
    logic [LB-1:0] m_fill = '0;

    initial begin
        logic          s_rst, s_rd, s_wr, s_ack, exp_err;
        logic [WW-1:0] s_rdata;
        logic [AW-1:0] s_addr;
        logic [LB-1:0] s_wb;
        forever begin
            @(posedge clk);
            s_rst = rst; s_rd = mem_read; s_wr = mem_write; s_ack = mem_bus.ext_ack;
            s_rdata = mem_bus.ext_rdata; s_addr = line_addr; s_wb = wb_line;
            @(negedge clk);
            exp_err = 1'b0;
            if (!rst || !s_rst) begin
                m_phase = 0; m_beat = 0; m_fill = '0;
            end else if (m_phase == 0) begin
                if (s_rd && s_wr) exp_err = 1'b1;
                else if (s_rd || s_wr) begin
                    m_phase = 1; m_beat = 0; m_we = s_wr;
                    m_base = s_addr & ~32'h1F; m_wb = s_wb;
                end
            end else begin
                if (s_rd || s_wr) exp_err = 1'b1;
                if (m_phase == 2) m_phase = 0;
                else if (s_ack) begin
                    if (!m_we) m_fill[m_beat*WW +: WW] = s_rdata;
                    if (m_beat == LW - 1) m_phase = 2;
                    else m_beat++;
                end
            end
            if (ca_resp) n_resp_seen++;
            if (error) n_err_seen++;
            check("busy", LB'(busy), LB'(m_phase != 0));
            check("ca_resp", LB'(ca_resp), LB'(m_phase == 2));
            check("error", LB'(error), LB'(exp_err));
            check("ext_req", LB'(mem_bus.ext_req), LB'(m_phase == 1));
            check("fill_line", fill_line, m_fill);
            if (m_phase == 1) begin
                check("ext_we", LB'(mem_bus.ext_we), LB'(m_we));
                check("ext_addr", LB'(mem_bus.ext_addr), LB'(m_base + AW'(m_beat * 4)));
                if (m_we) check("ext_wdata", LB'(mem_bus.ext_wdata), LB'(m_wb[m_beat*WW +: WW]));
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LB-1:0] wb);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; line_addr = a; wb_line = wb;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while ((busy || m_phase != 0) && k < max_cyc);
        if (k >= max_cyc) begin
            n_vec++; n_miss++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_wdata.delete();
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, " ext_req"}, LB'(mem_bus.ext_req), '0);
        check({name, " ext_we"}, LB'(mem_bus.ext_we), '0);
        check({name, " ext_addr"}, LB'(mem_bus.ext_addr), '0);
        check({name, " ext_wdata"}, LB'(mem_bus.ext_wdata), '0);
        check({name, " busy"}, LB'(busy), '0);
        check({name, " ca_resp"}, LB'(ca_resp), '0);
        check({name, " error"}, LB'(error), '0);
        check({name, " fill_line"}, fill_line, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] exp_line, wbv;
        int k, r0, e0;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; line_addr = '0; wb_line = '0;
        repeat (3) @(negedge clk);
        #1 check_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Fill, zero-wait memory: pulse cycle plus 9 more cycles to ca_resp.
        read_base = 32'hA0; clear_log();
        issue(1'b1, 1'b0, 32'h0000_1234, '0);
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!ca_resp && k < 50);
        check("fill latency", LB'(k), LB'(9));
        for (int i = 0; i < LW; i++) exp_line[i*WW +: WW] = 32'hA0 + 32'(i);
        check("fill data", fill_line, exp_line);
        check("fill beats", LB'(log_addr.size()), LB'(8));
        check("fill first addr", LB'(log_addr[0]), LB'(32'h1220));
        check("fill last addr", LB'(log_addr[7]), LB'(32'h123C));
        // Back-to-back: request in the cycle right after ca_resp is accepted.
        read_base = 32'hB0; clear_log();
        issue(1'b1, 1'b0, 32'h0000_2000, '0);
        @(negedge clk); #1;
        check("b2b accepted", LB'(busy), LB'(1));
        wait_idle("b2b fill", 100);

        // Writeback, 3 wait cycles per beat.
        mem_wait = 3; clear_log(); r0 = n_resp_seen;
        for (int i = 0; i < LW; i++) wbv[i*WW +: WW] = 32'h100 + 32'(i);
        issue(1'b0, 1'b1, 32'h0000_8A44, wbv);
        wait_idle("writeback", 200);
        check("wb beats", LB'(log_addr.size()), LB'(8));
        for (int i = 0; i < log_addr.size() && i < LW; i++) begin
            check("wb we", LB'(log_we[i]), LB'(1));
            check("wb wdata", LB'(log_wdata[i]), LB'(32'h100 + 32'(i)));
        end
        check("wb resp count", LB'(n_resp_seen - r0), LB'(1));
        check("wb busy after", LB'(busy), '0);

        // Simultaneous read+write in IDLE.
        mem_wait = 0; e0 = n_err_seen; r0 = n_resp_seen;
        issue(1'b1, 1'b1, 32'h0000_4000, '1);
        repeat (6) @(negedge clk); #1;
        check("both err count", LB'(n_err_seen - e0), LB'(1));
        check("both no resp", LB'(n_resp_seen - r0), '0);

        // Write while a fill is in progress.
        mem_wait = 2; read_base = 32'h7700; e0 = n_err_seen; r0 = n_resp_seen;
        issue(1'b1, 1'b0, 32'h0000_5A00, '0);
        repeat (4) @(posedge clk); #1 mem_write = 1'b1;
        @(posedge clk); #1 mem_write = 1'b0;
        wait_idle("busy req", 200);
        check("busy req err", LB'(n_err_seen - e0), LB'(1));
        check("busy req resp", LB'(n_resp_seen - r0), LB'(1));

        // Asynchronous reset during beat 4 of a fill.
        mem_wait = 0; read_base = 32'h5000; clear_log();
        issue(1'b1, 1'b0, 32'h0000_3300, '0);
        k = 0;
        while (log_addr.size() < 5 && k < 50) begin @(negedge clk); #1; k++; end
        r0 = n_resp_seen;
        #2 rst = 1'b0;
        #1 check_zero_outputs("async reset");
        repeat (3) @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(negedge clk); #1;
        check("reset no resp", LB'(n_resp_seen - r0), '0);
        clear_log();
        issue(1'b1, 1'b0, 32'h0000_3300, '0);
        wait_idle("post reset fill", 100);
        check("post reset beats", LB'(log_addr.size()), LB'(8));
        check("post reset first", LB'(log_addr[0]), LB'(32'h3300));

        // Randomized bursts with random waits, stray acks and intrusive requests.
        wait_rand = 1; spurious_en = 1;
        for (int n = 0; n < 30; n++) begin
            logic rd;
            rd = 1'(($urandom_range(0, 1)));
            read_base = $urandom;
            for (int i = 0; i < LW; i++) wbv[i*WW +: WW] = $urandom;
            issue(rd, !rd, $urandom, wbv);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                if (mem_bus.ext_req) begin
                    mem_read = 1'($urandom_range(0, 1)); mem_write = 1'b1;
                    @(posedge clk); #1 mem_read = 1'b0; mem_write = 1'b0;
                end
            end
            wait_idle("random burst", 300);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_rand = 0; spurious_en = 0;

        // Memory never acks: without the timeout build ext_req stays high.
        mem_stall = 1;
        issue(1'b1, 1'b0, 32'h0000_6000, '0);
        repeat (60) @(negedge clk); #1;
        check("stall ext_req", LB'(mem_bus.ext_req), LB'(1));
        check("stall busy", LB'(busy), LB'(1));
        #2 rst = 1'b0;
        repeat (2) @(posedge clk); #1 rst = 1'b1; mem_stall = 0;
        repeat (3) @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_line_adapter.md
Name: mem_line_adapter

Overview:
- Downstream of cache_control. Turns its single-cycle mem_read / mem_write pulses into a burst of LINE_WORDS word transfers on a simple req/ack main-memory port.
- Writeback: serialises the victim line out to memory. Fill: assembles the returned line for the cache data arrays.
- Signals completion to cache_control with a one-cycle ca_resp pulse.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, memory word width in bits; must be a multiple of 8.
- LINE_WORDS, 8, words per cache line; power of 2, at least 2.
- TIMEOUT, 255, max cycles to wait for ext_ack per beat (only used with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  one-cycle fill request from cache_control.
- mem_write  in  1  one-cycle writeback request from cache_control.
- line_addr  in  ADDR_W  line address; offset bits are ignored.
- wb_line  in  WORD_W*LINE_WORDS  victim line; word 0 occupies the LSBs.
- fill_line  out  WORD_W*LINE_WORDS  assembled fill line; valid when ca_resp is high.
- ca_resp  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance until the ca_resp cycle, inclusive.
- error  out  1  one-cycle protocol/timeout error pulse.
- ext_req  out  1  memory beat request.
- ext_we  out  1  1 = write beat, 0 = read beat.
- ext_addr  out  ADDR_W  byte address of the current beat.
- ext_wdata  out  WORD_W  write data for the current beat.
- ext_rdata  in  WORD_W  read data; valid when ext_ack is high.
- ext_ack  in  1  beat complete.

Behaviour:
- Reset (rst low, asynchronous) drives the following to 0 immediately: all outputs, fill_line, beat counter, timeout counter, and state (IDLE).
- Reset mid-burst aborts the transfer. No ca_resp is produced and the partial fill is discarded.
- OFF = log2(LINE_WORDS*WORD_W/8).
- Base address = line_addr with bits [OFF-1:0] forced to 0.
- ext_addr = base + beat*(WORD_W/8), where beat is a counter of log2(LINE_WORDS) bits.
- States:
  - IDLE:
    - mem_write alone: latch base and wb_line; ext_we <= 1; go to XFER.
    - mem_read alone: latch base; ext_we <= 0; go to XFER.
    - mem_read and mem_write together: pulse error, stay in IDLE, accept neither.
  - XFER:
    - ext_req is high; ext_addr, ext_we and ext_wdata (latched word[beat]) stay stable until ext_ack is sampled high.
    - On ack in a read burst, capture ext_rdata into fill_line word[beat].
    - On ack with beat < LINE_WORDS-1: beat increments. The next beat's ext_req follows with no idle cycle, so ext_req stays high across beats.
    - On ack with beat = LINE_WORDS-1: drop ext_req, go to DONE.
  - DONE: ca_resp = 1 for exactly one cycle; beat <= 0; go to IDLE.
  - ERR (only with MEM_TIMEOUT_EN): error = 1 for one cycle, ca_resp = 1 for the same cycle, go to IDLE.
- Latency with zero-wait memory (ack in the cycle after req is seen): acceptance edge, LINE_WORDS ack cycles, then ca_resp. Total = LINE_WORDS+2 cycles from the request pulse to ca_resp.
- ext_ack while ext_req is low is ignored.
- mem_read or mem_write while busy: the request is ignored, error pulses for one cycle, and the current burst continues unaffected.
- A new request is accepted in the cycle immediately after ca_resp.
- fill_line holds its value until the next read burst overwrites it word by word. After a write burst, fill_line is unchanged.
- Beat counter wraps only through DONE; it never overflows inside XFER.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A per-beat counter resets on each ack and counts cycles with ext_req high and no ack.
  - When it reaches TIMEOUT: drop ext_req, go to ERR (error and ca_resp pulse together, fill_line contents undefined), return to IDLE.
- MEM_TIMEOUT_EN undefined: no counter and no ERR state; XFER waits forever for ext_ack.

Test Plan:
- Fill, zero-wait memory, line_addr=0x0000_1234: ext_addr steps 0x1220, 0x1224, … 0x123C. Memory returns 0xA0..0xA7. ca_resp appears 10 cycles after the mem_read pulse, with fill_line words 0..7 = 0xA0..0xA7.
- Writeback, wb_line word i = 0x100+i, memory inserts 3 wait cycles per beat: ext_we=1 throughout. ext_wdata holds 0x100+i steady until each ack. Exactly 8 acks, then one ca_resp pulse; busy falls after it.
- mem_read and mem_write in the same cycle in IDLE: error for 1 cycle, ext_req stays 0, no ca_resp. A mem_write issued 5 cycles into a fill: error for 1 cycle, and the fill completes normally.
- rst low asynchronously during beat 4 of a fill: all outputs go to 0 before the next edge, no ca_resp. After rst returns high, a new mem_read runs a full 8-beat burst from beat 0.
- MEM_TIMEOUT_EN with TIMEOUT=16 and memory never acking beat 2: after 16 cycles ext_req drops, error and ca_resp pulse together, state returns to IDLE. Without the macro, ext_req stays high indefinitely.
